// File: rtl/galpal_gal_prog.sv
// Parametrised in-system-programmable GAL: fuse array loaded serially with a byte-sum
// checksum, AND/OR array feeding N_OLMC macrocells that are registered or combinational.
module galpal_gal_prog #(
    parameter int N_IN   = 12,
    parameter int N_OLMC = 10,
    parameter int PTERMS = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_IN-1:0]   I,
    inout  wire  [N_OLMC-1:0] IOQ,
    input  logic              PROG,
    input  logic              FUSE_EN,
    input  logic              FUSE_DI,
    output logic              DONE,
    output logic              ERR,
    output logic [15:0]       CSUM
);

    localparam int NT         = N_IN + N_OLMC;
    localparam int W          = 2 * NT;
    localparam int OLMC_SPAN  = W * (1 + PTERMS);
    localparam int SP_BASE    = W + N_OLMC * OLMC_SPAN;
    localparam int FUSE_COUNT = W * (2 + N_OLMC * (1 + PTERMS)) + 2 * N_OLMC;
    localparam int MODE_BASE  = FUSE_COUNT - 2 * N_OLMC;
    localparam int CW         = $clog2(FUSE_COUNT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                state, state_nxt;
    logic [FUSE_COUNT-1:0] fuse;
    logic [CW-1:0]         cnt;
    logic [N_OLMC-1:0]     q;

    logic [N_OLMC-1:0] fb, mode_comb, mode_pos, oe_t, sum_t, pin_val;
    logic [NT-1:0]     sig;
    logic [W-1:0]      lit;
    logic              ar_t, sp_t, load_full;

    assign load_full = (cnt == CW'(FUSE_COUNT));

    // Signal columns: dedicated inputs first, then macrocell feedback.
    assign sig = {fb, I};

    for (genvar s = 0; s < NT; s++) begin : g_lit
        assign lit[2*s]   = sig[s];
        assign lit[2*s+1] = ~sig[s];
    end

    // A blown fuse (1) forces its literal high, i.e. disconnects it from the AND.
    assign ar_t = &(lit | fuse[0 +: W]);
    assign sp_t = &(lit | fuse[SP_BASE +: W]);

    for (genvar k = 0; k < N_OLMC; k++) begin : g_olmc
        localparam int BASE = W + k * OLMC_SPAN;
        logic [PTERMS-1:0] terms;

        for (genvar p = 0; p < PTERMS; p++) begin : g_term
            assign terms[p] = &(lit | fuse[BASE + (p + 1) * W +: W]);
        end

        assign mode_pos[k]  = fuse[MODE_BASE + 2*k];
        assign mode_comb[k] = fuse[MODE_BASE + 2*k + 1];
        assign oe_t[k]      = &(lit | fuse[BASE +: W]);
        assign sum_t[k]     = |terms;
        assign fb[k]        = mode_comb[k] ? IOQ[k] : q[k];
        assign pin_val[k]   = mode_comb[k] ? (mode_pos[k] ? sum_t[k] : ~sum_t[k])
                                           : (mode_pos[k] ? q[k]     : ~q[k]);
        assign IOQ[k]       = (oe_t[k] && state == RUN) ? pin_val[k] : 1'bz;
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves state_nxt latched.
        state_nxt = state;
        case (state)
            LOAD:    if (!PROG) state_nxt = load_full ? RUN : IDLE;
            default: if (PROG)  state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the whole fuse array is reset, so a reset device never runs a stale image.
            fuse <= '0;
            cnt  <= '0;
            CSUM <= '0;
            DONE <= 1'b0;
            ERR  <= 1'b0;
            q    <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (PROG) begin
                        if (FUSE_EN && !load_full) begin
                            fuse[cnt] <= FUSE_DI;
                            CSUM      <= CSUM + (16'(FUSE_DI) << cnt[2:0]);
                            cnt       <= cnt + CW'(1);
                        end
                    end else if (load_full) begin
                        DONE <= 1'b1;
                    end else begin
                        ERR <= 1'b1;
                    end
                end
                default: begin
                    if (PROG) begin
                        cnt  <= '0;
                        CSUM <= '0;
                        DONE <= 1'b0;
                        ERR  <= 1'b0;
                    end
                end
            endcase

            // Registers only evolve while running; AR outranks SP.
            if (state == RUN && !PROG) begin
                if (ar_t)      q <= '0;
                else if (sp_t) q <= '1;
                else           q <= sum_t;
            end else begin
                q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_galpal_gal_prog.sv
// Self-checking bench for galpal_gal_prog in a 2-input / 2-macrocell / 2-term geometry:
// directed vector tables plus random fuse maps checked against a behavioural model.
module tb_galpal_gal_prog;

    localparam int N_IN      = 2;
    localparam int N_OLMC    = 2;
    localparam int PTERMS    = 2;
    localparam int W         = 8;
    localparam int FC        = 68;
    localparam int SPAN      = W * (1 + PTERMS);
    localparam int SP_BASE   = W + N_OLMC * SPAN;
    localparam int MODE_BASE = FC - 2 * N_OLMC;
    localparam logic [1:0] PZ = 2'd2;  // pin code for high impedance

    logic        CLK = 1'b0;
    logic        RST, PROG, FUSE_EN, FUSE_DI;
    logic [1:0]  I;
    wire  [1:0]  IOQ;
    logic        DONE, ERR;
    logic [15:0] CSUM;

    galpal_gal_prog #(.N_IN(N_IN), .N_OLMC(N_OLMC), .PTERMS(PTERMS)) dut (
        .CLK(CLK), .RST(RST), .I(I), .IOQ(IOQ), .PROG(PROG),
        .FUSE_EN(FUSE_EN), .FUSE_DI(FUSE_DI), .DONE(DONE), .ERR(ERR), .CSUM(CSUM)
    );

    always #5 CLK = ~CLK;

    // Each pin encoded as 0, 1 or 2 (Z), pin 1 in the upper pair.
    wire       z0 = (IOQ[0] === 1'bz);
    wire       z1 = (IOQ[1] === 1'bz);
    wire [3:0] ioq_code = {(z1 ? PZ : {1'b0, IOQ[1]}), (z0 ? PZ : {1'b0, IOQ[0]})};

    int checks = 0;
    int errors = 0;

    logic [127:0] img;
    logic [1:0]   mq;

    typedef struct {
        logic [1:0] i;
        logic [3:0] exp_ioq;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_img(input int n);
        PROG = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            FUSE_EN = 1'b1;
            FUSE_DI = img[i];
            tick();
        end
        FUSE_EN = 1'b0;
        PROG    = 1'b0;
        tick();
    endtask

    function automatic logic [15:0] csum_of(input int n);
        int s = 0;
        for (int i = 0; i < n && i < FC; i++)
            if (img[i]) s += 1 << (i % 8);
        return 16'(s);
    endfunction

    // Term is true unless some connected literal evaluates false.
    function automatic logic term_on(input int base, input logic [3:0] sv);
        for (int c = 0; c < W; c++) begin
            if (img[base + c] == 1'b0) begin
                if ((c % 2 == 0) ? !sv[c / 2] : sv[c / 2]) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [3:0] sigs(input logic [1:0] iv);
        logic [3:0] sv;
        sv[1:0] = iv;
        for (int k = 0; k < N_OLMC; k++)
            sv[2 + k] = img[MODE_BASE + 2*k + 1] ? 1'b0 : mq[k];
        return sv;
    endfunction

    function automatic logic sum_of(input int k, input logic [3:0] sv);
        logic r = 1'b0;
        for (int p = 0; p < PTERMS; p++)
            if (term_on(W + k * SPAN + (p + 1) * W, sv)) r = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] model_pins(input logic [1:0] iv);
        logic [3:0] sv = sigs(iv);
        logic [3:0] code;
        logic       v;
        for (int k = 0; k < N_OLMC; k++) begin
            v = img[MODE_BASE + 2*k + 1] ? sum_of(k, sv) : mq[k];
            if (!img[MODE_BASE + 2*k]) v = !v;
            code[2*k +: 2] = term_on(W + k * SPAN, sv) ? {1'b0, v} : PZ;
        end
        return code;
    endfunction

    function automatic logic [1:0] model_next(input logic [1:0] iv);
        logic [3:0] sv = sigs(iv);
        logic [1:0] n;
        for (int k = 0; k < N_OLMC; k++) begin
            if (term_on(0, sv))            n[k] = 1'b0;
            else if (term_on(SP_BASE, sv)) n[k] = 1'b1;
            else                           n[k] = sum_of(k, sv);
        end
        return n;
    endfunction

    vec_t and_vecs[6];

    initial begin
        and_vecs[0] = '{2'b11, {PZ, 2'd1}};
        and_vecs[1] = '{2'b01, {PZ, 2'd0}};
        and_vecs[2] = '{2'b10, {PZ, 2'd0}};
        and_vecs[3] = '{2'b11, {PZ, 2'd1}};
        and_vecs[4] = '{2'b11, {PZ, 2'd1}};
        and_vecs[5] = '{2'b00, {PZ, 2'd0}};

        RST = 1'b1; PROG = 1'b0; FUSE_EN = 1'b0; FUSE_DI = 1'b0; I = 2'b00;
        tick(); tick();
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_err",  32'(ERR),  32'd0);
        check("rst_csum", 32'(CSUM), 32'h0);
        check("rst_ioq",  32'(ioq_code), 32'({PZ, PZ}));
        RST = 1'b0;
        tick(); tick();
        check("idle_ioq", 32'(ioq_code), 32'({PZ, PZ}));

        // All fuses blown: every term true, both pins combinational active-high.
        img = '1;
        load_img(FC);
        check("full_csum", 32'(CSUM), 32'h0807);
        check("full_done", 32'(DONE), 32'd1);
        check("full_err",  32'(ERR),  32'd0);
        check("full_ioq",  32'(ioq_code), 32'({2'd1, 2'd1}));
        I = 2'b10; tick();
        check("full_ioq_run", 32'(ioq_code), 32'({2'd1, 2'd1}));

        PROG = 1'b1; tick();
        check("reprog_done", 32'(DONE), 32'd0);
        check("reprog_csum", 32'(CSUM), 32'h0);
        check("reprog_ioq",  32'(ioq_code), 32'({PZ, PZ}));

        load_img(10);
        check("short_err",  32'(ERR),  32'd1);
        check("short_done", 32'(DONE), 32'd0);
        check("short_csum", 32'(CSUM), 32'h0102);
        check("short_ioq",  32'(ioq_code), 32'({PZ, PZ}));

        load_img(75);
        check("extra_csum", 32'(CSUM), 32'h0807);
        check("extra_done", 32'(DONE), 32'd1);

        // Registered AND of I[0] and I[1] on OLMC0, OLMC1 disabled.
        img = '0;
        img[8 +: W] = '1;
        img[16 +: W] = 8'b1111_1010;
        img[MODE_BASE] = 1'b1;
        load_img(FC);
        check("and_done", 32'(DONE), 32'd1);
        check("and_init", 32'(ioq_code), 32'({PZ, 2'd0}));
        for (int v = 0; v < 6; v++) begin
            I = and_vecs[v].i;
            tick();
            check($sformatf("and_vec%0d", v), 32'(ioq_code), 32'(and_vecs[v].exp_ioq));
        end

        // SP alone presets; AR and SP together clear.
        img[SP_BASE +: W] = '1;
        load_img(FC);
        I = 2'b00; tick();
        check("sp_only", 32'(ioq_code), 32'({PZ, 2'd1}));
        img[0 +: W] = '1;
        load_img(FC);
        I = 2'b11; tick(); tick();
        check("ar_beats_sp", 32'(ioq_code), 32'({PZ, 2'd0}));

        // Random fuse maps; a combinational macrocell's own feedback column is disconnected.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < FC; i++) img[i] = ($urandom_range(3) != 0);
            if (t % 2 == 0) img[0 +: W] = '0;
            if (t % 3 != 0) img[SP_BASE +: W] = '0;
            for (int k = 0; k < N_OLMC; k++) begin
                if (img[MODE_BASE + 2*k + 1]) begin
                    for (int b = 0; b < SP_BASE + W; b += W) begin
                        img[b + 2*(N_IN + k)]     = 1'b1;
                        img[b + 2*(N_IN + k) + 1] = 1'b1;
                    end
                end
            end
            load_img(FC);
            check($sformatf("rnd%0d_csum", t), 32'(CSUM), 32'(csum_of(FC)));
            check($sformatf("rnd%0d_done", t), 32'(DONE), 32'd1);
            mq = 2'b00;
            for (int c = 0; c < 16; c++) begin
                I = 2'($urandom);
                #1;
                check($sformatf("rnd%0d_c%0d_ioq", t, c), 32'(ioq_code), 32'(model_pins(I)));
                mq = model_next(I);
                tick();
            end
        end

        // Reset wins over PROG; the first clean PROG edge only enters LOAD.
        RST = 1'b1; PROG = 1'b1; tick();
        check("rstprog_done", 32'(DONE), 32'd0);
        check("rstprog_csum", 32'(CSUM), 32'h0);
        check("rstprog_ioq",  32'(ioq_code), 32'({PZ, PZ}));
        RST = 1'b0; FUSE_EN = 1'b1; FUSE_DI = 1'b1; tick();
        check("enter_load_csum", 32'(CSUM), 32'h0);
        tick();
        check("first_bit_csum", 32'(CSUM), 32'h1);
        FUSE_EN = 1'b0; PROG = 1'b0; tick();
        check("after_rst_short_err", 32'(ERR), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
